// File: rtl/cpu_pkg.sv
// Shared execute-stage types: ALU opcodes, multi-cycle iteration count, muldiv FSM states.
// No logic of its own, so there is no latency.
// No backpressure: it only holds definitions.
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_DIVU = 4'd11,
    ALU_REMU = 4'd12
  } alu_op_e;

  localparam int MC_ITERATIONS = 32;
  localparam int MC_CNT_W      = $clog2(MC_ITERATIONS);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // True for the ops that are handled by the iterative muldiv unit.
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL / DIVU / REMU, one bit per cycle.
// Latency: capture edge plus 32 iterations in BUSY, result held during DONE.
// Backpressure: start is accepted only in IDLE; flush returns to IDLE from any state.
module muldiv_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        flush,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  // acc: product accumulator (MUL) or partial remainder (DIVU/REMU)
  // x:   shifting multiplicand (MUL) or dividend shifting into quotient
  // y:   shifting multiplier (MUL) or the fixed divisor
  md_state_e             state_q, state_d;
  logic [MC_CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]            op_q, op_d;
  logic [31:0]           acc_q, acc_d;
  logic [31:0]           x_q, x_d;
  logic [31:0]           y_q, y_d;

  logic [32:0]           rem_shift;
  logic [32:0]           rem_sub;

  // Next-state and one datapath iteration per BUSY cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    x_d       = x_q;
    y_d       = y_q;
    // Restoring division step: bring in the next dividend bit, try subtracting.
    rem_shift = {acc_q, x_q[31]};
    rem_sub   = rem_shift - {1'b0, y_q};

    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = MC_CNT_W'(MC_ITERATIONS - 1);
          op_d    = op;
          acc_d   = '0;
          x_d     = a;
          y_d     = b;
        end
      end
      MD_BUSY: begin
        if (op_q == ALU_MUL) begin
          if (y_q[0]) begin
            acc_d = acc_q + x_q;
          end
          x_d = {x_q[30:0], 1'b0};
          y_d = {1'b0, y_q[31:1]};
        end else if (!rem_sub[32]) begin
          // A zero divisor always subtracts, giving all-ones quotient and
          // leaving the dividend as remainder.
          acc_d = rem_sub[31:0];
          x_d   = {x_q[30:0], 1'b1};
        end else begin
          acc_d = rem_shift[31:0];
          x_d   = {x_q[30:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase

    if (flush) begin
      state_d = MD_IDLE;
    end
  end

  // State, counter and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign busy   = (state_q == MD_BUSY);
  assign done   = (state_q == MD_DONE);
  assign result = (op_q == ALU_DIVU) ? x_q : acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus iterative muldiv, registered into the EX/MEM outputs.
// Latency: 1 edge for ALU ops; 34 edges for MUL/DIVU/REMU (33 stall cycles, result on the DONE edge).
// Backpressure: ex_stall holds upstream while a multi-cycle op runs; ex_flush kills and drops stall.
module ex_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_ex_valid,
  input  logic [3:0]  id_ex_alu_op,
  input  logic [31:0] id_ex_operand_a,
  input  logic [31:0] id_ex_operand_b,
  input  logic [31:0] id_ex_operand_val1,
  input  logic [31:0] id_ex_operand_val2,
  input  logic [1:0]  id_ex_regwrite,
  input  logic [2:0]  id_ex_wb_enc,
  input  logic [2:0]  id_ex_data_select_hotcode,
  input  logic [4:0]  id_ex_memory_access_code,
  input  logic [31:0] ex_instruct,
  input  logic        ex_flush,
  output logic        ex_stall,
  output logic [1:0]  ex_mem_regwrite,
  output logic [2:0]  ex_mem_reg_wb_enc,
  output logic [31:0] ex_mem_reg_arithmetic_result,
  output logic [31:0] ex_mem_reg_operand_val1,
  output logic [31:0] ex_mem_reg_operand_val2,
  output logic [2:0]  ex_mem_reg_data_select_hotcode,
  output logic [4:0]  ex_mem_reg_memory_access_code,
  output logic [31:0] mem_instruct
);

  logic        mc_op;
  logic        md_busy;
  logic        md_done;
  logic        md_idle;
  logic        md_start;
  logic [31:0] md_result;
  logic [31:0] alu_result;
  logic [4:0]  shamt;
  logic        load_bubble;

  logic [1:0]  regwrite_q, regwrite_d;
  logic [2:0]  wb_enc_q, wb_enc_d;
  logic [31:0] result_q, result_d;
  logic [31:0] val1_q, val1_d;
  logic [31:0] val2_q, val2_d;
  logic [2:0]  dsel_q, dsel_d;
  logic [4:0]  mac_q, mac_d;
  logic [31:0] instr_q, instr_d;

  assign mc_op   = is_multicycle(id_ex_alu_op);
  assign md_idle = !md_busy && !md_done;
  assign shamt   = id_ex_operand_b[4:0];

  // Upstream holds while an op is being launched or iterating; a flush
  // always releases it so the killed instruction can be replaced.
  assign ex_stall = !ex_flush && ((md_idle && id_ex_valid && mc_op) || md_busy);
  assign md_start = md_idle && id_ex_valid && mc_op && !ex_flush;

  // Any cycle that is not a clean, unstalled, valid instruction loads a bubble.
  // With stall low and a multi-cycle op valid, the unit is necessarily in DONE.
  assign load_bubble = ex_stall || ex_flush || !id_ex_valid;

  muldiv_unit u_muldiv (
    .clk    (clk),
    .resetn (resetn),
    .start  (md_start),
    .flush  (ex_flush),
    .op     (id_ex_alu_op),
    .a      (id_ex_operand_a),
    .b      (id_ex_operand_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // Single-cycle ALU; unused codes produce zero.
  always_comb begin
    alu_result = '0;
    case (id_ex_alu_op)
      ALU_ADD:  alu_result = id_ex_operand_a + id_ex_operand_b;
      ALU_SUB:  alu_result = id_ex_operand_a - id_ex_operand_b;
      ALU_AND:  alu_result = id_ex_operand_a & id_ex_operand_b;
      ALU_OR:   alu_result = id_ex_operand_a | id_ex_operand_b;
      ALU_XOR:  alu_result = id_ex_operand_a ^ id_ex_operand_b;
      ALU_SLL:  alu_result = id_ex_operand_a << shamt;
      ALU_SRL:  alu_result = id_ex_operand_a >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(id_ex_operand_a) >>> shamt);
      ALU_SLT:  alu_result = {31'b0, $signed(id_ex_operand_a) < $signed(id_ex_operand_b)};
      ALU_SLTU: alu_result = {31'b0, id_ex_operand_a < id_ex_operand_b};
      default:  alu_result = '0;
    endcase
  end

  // Next value of the EX/MEM register: instruction fields or an all-zero bubble.
  always_comb begin
    regwrite_d = '0;
    wb_enc_d   = '0;
    result_d   = '0;
    val1_d     = '0;
    val2_d     = '0;
    dsel_d     = '0;
    mac_d      = '0;
    instr_d    = '0;
    if (!load_bubble) begin
      regwrite_d = id_ex_regwrite;
      wb_enc_d   = id_ex_wb_enc;
      result_d   = mc_op ? md_result : alu_result;
      val1_d     = id_ex_operand_val1;
      val2_d     = id_ex_operand_val2;
      dsel_d     = id_ex_data_select_hotcode;
      mac_d      = id_ex_memory_access_code;
      instr_d    = ex_instruct;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regwrite_q <= '0;
      wb_enc_q   <= '0;
      result_q   <= '0;
      val1_q     <= '0;
      val2_q     <= '0;
      dsel_q     <= '0;
      mac_q      <= '0;
      instr_q    <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      wb_enc_q   <= wb_enc_d;
      result_q   <= result_d;
      val1_q     <= val1_d;
      val2_q     <= val2_d;
      dsel_q     <= dsel_d;
      mac_q      <= mac_d;
      instr_q    <= instr_d;
    end
  end

  assign ex_mem_regwrite                = regwrite_q;
  assign ex_mem_reg_wb_enc              = wb_enc_q;
  assign ex_mem_reg_arithmetic_result   = result_q;
  assign ex_mem_reg_operand_val1        = val1_q;
  assign ex_mem_reg_operand_val2        = val2_q;
  assign ex_mem_reg_data_select_hotcode = dsel_q;
  assign ex_mem_reg_memory_access_code  = mac_q;
  assign mem_instruct                   = instr_q;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed bench for ex_stage with a queue-based scoreboard.
// Expected outputs come from a plain-arithmetic model of the opcode table.
// Stall length and bubbles are checked by the driver; outputs by the monitor.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_ex_valid;
  logic [3:0]  id_ex_alu_op;
  logic [31:0] id_ex_operand_a, id_ex_operand_b;
  logic [31:0] id_ex_operand_val1, id_ex_operand_val2;
  logic [1:0]  id_ex_regwrite;
  logic [2:0]  id_ex_wb_enc, id_ex_data_select_hotcode;
  logic [4:0]  id_ex_memory_access_code;
  logic [31:0] ex_instruct;
  logic        ex_flush;
  logic        ex_stall;
  logic [1:0]  ex_mem_regwrite;
  logic [2:0]  ex_mem_reg_wb_enc;
  logic [31:0] ex_mem_reg_arithmetic_result;
  logic [31:0] ex_mem_reg_operand_val1, ex_mem_reg_operand_val2;
  logic [2:0]  ex_mem_reg_data_select_hotcode;
  logic [4:0]  ex_mem_reg_memory_access_code;
  logic [31:0] mem_instruct;

  logic [140:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk                            (clk),
    .resetn                         (resetn),
    .id_ex_valid                    (id_ex_valid),
    .id_ex_alu_op                   (id_ex_alu_op),
    .id_ex_operand_a                (id_ex_operand_a),
    .id_ex_operand_b                (id_ex_operand_b),
    .id_ex_operand_val1             (id_ex_operand_val1),
    .id_ex_operand_val2             (id_ex_operand_val2),
    .id_ex_regwrite                 (id_ex_regwrite),
    .id_ex_wb_enc                   (id_ex_wb_enc),
    .id_ex_data_select_hotcode      (id_ex_data_select_hotcode),
    .id_ex_memory_access_code       (id_ex_memory_access_code),
    .ex_instruct                    (ex_instruct),
    .ex_flush                       (ex_flush),
    .ex_stall                       (ex_stall),
    .ex_mem_regwrite                (ex_mem_regwrite),
    .ex_mem_reg_wb_enc              (ex_mem_reg_wb_enc),
    .ex_mem_reg_arithmetic_result   (ex_mem_reg_arithmetic_result),
    .ex_mem_reg_operand_val1        (ex_mem_reg_operand_val1),
    .ex_mem_reg_operand_val2        (ex_mem_reg_operand_val2),
    .ex_mem_reg_data_select_hotcode (ex_mem_reg_data_select_hotcode),
    .ex_mem_reg_memory_access_code  (ex_mem_reg_memory_access_code),
    .mem_instruct                   (mem_instruct)
  );

  logic [140:0] dut_out;
  assign dut_out = {ex_mem_regwrite, ex_mem_reg_wb_enc, ex_mem_reg_arithmetic_result,
                    ex_mem_reg_operand_val1, ex_mem_reg_operand_val2,
                    ex_mem_reg_data_select_hotcode, ex_mem_reg_memory_access_code,
                    mem_instruct};

  // Reference model: the opcode table written as plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] prod;
    prod = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return $unsigned($signed(a) >>> b[4:0]);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return prod[31:0];
      4'd11: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd12: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [140:0] act, input logic [140:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every real instruction leaving the stage must match the head of the queue.
  always @(negedge clk) begin
    if (resetn === 1'b1 && mem_instruct != 32'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", dut_out, 141'd0);
      end else begin
        check("scoreboard", dut_out, exp_q.pop_front());
      end
    end
  end

  // Present one instruction at a negedge and hold it while stalled.
  // flush_at >= 0 raises ex_flush after that many stall cycles instead of completing.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int flush_at);
    int  stall_cnt;
    logic mc;
    mc = (op >= 4'd10) && (op <= 4'd12);
    id_ex_valid               = 1'b1;
    id_ex_alu_op              = op;
    id_ex_operand_a           = a;
    id_ex_operand_b           = b;
    id_ex_operand_val1        = $urandom;
    id_ex_operand_val2        = $urandom;
    id_ex_regwrite            = 2'($urandom);
    id_ex_wb_enc              = 3'($urandom);
    id_ex_data_select_hotcode = 3'($urandom);
    id_ex_memory_access_code  = 5'($urandom);
    ex_instruct               = $urandom | 32'd1;
    if (flush_at < 0) begin
      exp_q.push_back({id_ex_regwrite, id_ex_wb_enc, ref_result(op, a, b),
                       id_ex_operand_val1, id_ex_operand_val2,
                       id_ex_data_select_hotcode, id_ex_memory_access_code, ex_instruct});
    end
    stall_cnt = 0;
    #1;
    forever begin
      if (flush_at == stall_cnt) begin
        ex_flush = 1'b1;
        #1;
        check("flush_stall_low", 141'(ex_stall), 141'd0);
        break;
      end
      if (!ex_stall) break;
      stall_cnt++;
      if (stall_cnt > 40) begin
        check("stall_timeout", 141'(stall_cnt), 141'd33);
        break;
      end
      @(negedge clk);
      check("stall_bubble", dut_out, 141'd0);
      #1;
    end
    if (flush_at < 0) begin
      check("stall_len", 141'(stall_cnt), mc ? 141'd33 : 141'd0);
    end
    @(posedge clk);
    @(negedge clk);
    if (flush_at >= 0) begin
      check("flush_bubble", dut_out, 141'd0);
    end
    id_ex_valid = 1'b0;
    ex_flush    = 1'b0;
    if (flush_at >= 0) begin
      #1;
      check("post_flush_stall", 141'(ex_stall), 141'd0);
    end
  endtask

  initial begin
    resetn                    = 1'b0;
    id_ex_valid               = 1'b0;
    id_ex_alu_op              = '0;
    id_ex_operand_a           = '0;
    id_ex_operand_b           = '0;
    id_ex_operand_val1        = '0;
    id_ex_operand_val2        = '0;
    id_ex_regwrite            = '0;
    id_ex_wb_enc              = '0;
    id_ex_data_select_hotcode = '0;
    id_ex_memory_access_code  = '0;
    ex_instruct               = '0;
    ex_flush                  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out", dut_out, 141'd0);
    check("reset_stall", 141'(ex_stall), 141'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed corner cases.
    send(4'd0,  32'h7FFF_FFFF, 32'h0000_0001, -1);
    send(4'd7,  32'h8000_0000, 32'd4, -1);
    send(4'd8,  32'hFFFF_FFFF, 32'h0000_0001, -1);
    send(4'd10, 32'h0001_0001, 32'h0001_0001, -1);
    send(4'd11, 32'd100, 32'd7, -1);
    send(4'd12, 32'd100, 32'd7, -1);
    send(4'd11, 32'd5, 32'd0, -1);
    send(4'd12, 32'd5, 32'd0, -1);
    send(4'd14, 32'd9, 32'd9, -1);

    // Flush in the tenth BUSY cycle of a DIVU, then a normal ADD and a full DIVU.
    send(4'd11, 32'd1000, 32'd3, 10);
    send(4'd0,  32'd2, 32'd3, -1);
    send(4'd11, 32'hFFFF_FFFF, 32'd10, -1);

    // Asynchronous reset clears a loaded result without waiting for a clock.
    send(4'd3, 32'h1234_0000, 32'h0000_5678, -1);
    #2 resetn = 1'b0;
    #1 check("async_clear", dut_out, 141'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Reset during BUSY of a MUL: no stall, no stale result afterwards.
    id_ex_valid     = 1'b1;
    id_ex_alu_op    = 4'd10;
    id_ex_operand_a = 32'd12345;
    id_ex_operand_b = 32'd678;
    ex_instruct     = 32'hDEAD_BEEF;
    repeat (6) @(negedge clk);
    #2 resetn = 1'b0;
    id_ex_valid = 1'b0;
    #1 check("reset_busy_stall", 141'(ex_stall), 141'd0);
    check("reset_busy_out", dut_out, 141'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) begin
      @(negedge clk);
      check("no_stale", dut_out, 141'd0);
    end
    send(4'd11, 32'd100, 32'd7, -1);

    // Randomized traffic, including flushes at any point of a multi-cycle op.
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      int          fa;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'($urandom_range(0, 1000)); b = 32'($urandom_range(1, 40)); end
        2: a = 32'h8000_0000 | a;
        default: ;
      endcase
      fa = -1;
      if ($urandom_range(0, 9) == 0) begin
        fa = (op >= 4'd10 && op <= 4'd12) ? int'($urandom_range(0, 33)) : 0;
      end
      send(op, a, b, fa);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_drain", 141'(exp_q.size()), 141'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1: single rising-edge clock for all state.
REQ-002 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port id_ex_valid, input, 1: an instruction is presented this cycle.
REQ-004 SHALL have ports id_ex_alu_op (in, 4) and id_ex_operand_a / id_ex_operand_b (in, 32 each): ALU operation and its operands.
REQ-005 SHALL have ports id_ex_operand_val1 / id_ex_operand_val2 (in, 32 each): store data and memory address, passed through.
REQ-006 SHALL have ports id_ex_regwrite (in, 2), id_ex_wb_enc (in, 3), id_ex_data_select_hotcode (in, 3), id_ex_memory_access_code (in, 5) and ex_instruct (in, 32): metadata passed through.
REQ-007 SHALL have port ex_flush, input, 1: synchronous kill of the current instruction.
REQ-008 SHALL have port ex_stall, output, 1: upstream holds all id_ex_* inputs stable while it is high.
REQ-009 SHALL have registered outputs ex_mem_regwrite (2), ex_mem_reg_wb_enc (3), ex_mem_reg_arithmetic_result (32), ex_mem_reg_operand_val1 (32), ex_mem_reg_operand_val2 (32), ex_mem_reg_data_select_hotcode (3), ex_mem_reg_memory_access_code (5) and mem_instruct (32).

Function
REQ-010 SHALL implement single-cycle ops by code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU.
- Shift amount is operand_b[4:0].
- SLT and SLTU yield 0 or 1.
- All arithmetic wraps modulo 2^32.
REQ-011 SHALL implement multi-cycle ops: 10 MUL (low 32 bits of product), 11 DIVU, 12 REMU.
- All are unsigned and iterative, one bit per cycle.
REQ-012 SHALL produce result 0 for codes 13-15, with the metadata still passed through.
REQ-013 SHALL, for DIVU/REMU with divisor 0, produce quotient 0xFFFFFFFF and remainder equal to the dividend.
REQ-014 SHALL, on each edge with ex_stall low, load every ex_mem output from the id_ex inputs, with result from the ALU or muldiv unit.
REQ-015 SHALL, on each edge where the ex_mem outputs load a bubble, set all ex_mem outputs and mem_instruct to 0.
- Zero memory_access_code guarantees no memory write.
- A bubble is loaded when id_ex_valid is 0, when ex_flush is 1, or while ex_stall is 1.
REQ-016 SHALL implement the multi-cycle FSM with states IDLE, BUSY and DONE:
- IDLE -> BUSY when id_ex_valid is high and the op is multi-cycle; operands are captured and iteration counter = 31.
- BUSY: one iteration per edge, counter decrements; counter = 0 -> DONE.
- DONE -> IDLE unconditionally; on this edge the ex_mem outputs load the result.
REQ-017 SHALL drive ex_stall combinationally as (IDLE & id_ex_valid & multi-cycle op) | BUSY, so it is high for exactly 33 cycles per multi-cycle op.
REQ-018 SHALL, when ex_flush is high in any state, return the FSM to IDLE and load a bubble on that edge.
- Flush takes priority over completion in DONE.
- ex_stall SHALL be forced low while ex_flush is high.
REQ-019 SHALL allow back-to-back ops: an instruction presented in the cycle after DONE is accepted normally.

Reset
REQ-020 SHALL, on resetn low, clear all ex_mem outputs and mem_instruct to 0 immediately, set the FSM to IDLE and clear the counter and muldiv datapath registers.
REQ-021 SHALL, after reset is asserted mid-operation, drive ex_stall low and discard the pending op; no partial result may appear.

Structure
REQ-022 SHALL take the alu_op enumeration, MC_ITERATIONS = 32 and the FSM state typedef from shared package cpu_pkg.
REQ-023 SHALL place the iterative multiplier/divider (start, op, a, b -> busy, done, result) in one sub-module, muldiv_unit; the ALU SHALL stay in ex_stage.

Verification
REQ-024 SHALL cover ADD 0x7FFFFFFF + 0x00000001, valid=1 -> next edge ex_mem_reg_arithmetic_result = 0x80000000 and metadata passed through unchanged.
REQ-025 SHALL cover SRA 0x80000000 by 4 -> 0xF8000000, and SLT 0xFFFFFFFF vs 0x00000001 -> 1.
REQ-026 SHALL cover MUL 0x00010001 x 0x00010001 -> ex_stall high 33 cycles, then result 0x00020001; bubbles in ex_mem during the stall.
REQ-027 SHALL cover DIVU 100/7 -> 14 and REMU 100/7 -> 2, back to back; and DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5.
REQ-028 SHALL cover ex_flush in BUSY cycle 10 of a DIVU -> bubble, ex_stall low, IDLE next cycle, and a following ADD 2+3 -> 5.
REQ-029 SHALL cover resetn pulsed low during BUSY -> all outputs 0 asynchronously, ex_stall low, and no stale result after release.
